// File: rtl/lcd_bus_sequencer.sv
// HD44780-style LCD bus sequencer: turns each LCD register store into a timed
// setup / enable / hold / execution-wait cycle on the LCD pins.
module lcd_bus_sequencer #(
  parameter int SETUP_CYC      = 2,
  parameter int EN_HIGH_CYC    = 25,
  parameter int HOLD_CYC       = 2,
  parameter int EXEC_CYC       = 2000,
  parameter int CLEAR_EXEC_CYC = 82000,
  parameter int CNT_W          = 17
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_valid,
  input  logic [31:0] i_cmd_data,
  output logic        o_cmd_ready,
  output logic        o_busy,
  output logic        o_overrun,
  output logic [7:0]  o_rd_data,
  output logic        o_rd_valid,
  output logic        o_lcd_on,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_data_oe,
  input  logic [7:0]  i_lcd_data
);

  typedef enum logic [2:0] {IDLE, SETUP, EN_HI, HOLD, EXEC} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_load;
  logic             on_q, rs_q, rw_q;
  logic [7:0]       data_q;
  logic             last, accept, is_clear, ready;
  logic             unused_cmd_bits;

  assign unused_cmd_bits = ^i_cmd_data[30:10];
  assign last            = (cnt == '0);
  assign accept          = i_cmd_valid && ready;
  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  assign is_clear        = !rs_q && !rw_q && (data_q[7:2] == 6'd0);

  // State register and the shared down-counter, reloaded on every state change.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state)
        cnt <= cnt_load;
      else if (!last)
        cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      on_q       <= 1'b0;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      data_q     <= 8'd0;
      o_overrun  <= 1'b0;
      o_rd_data  <= 8'd0;
      o_rd_valid <= 1'b0;
    end else begin
      if (accept) begin
        on_q   <= i_cmd_data[31];
        rs_q   <= i_cmd_data[9];
        rw_q   <= i_cmd_data[8];
        data_q <= i_cmd_data[7:0];
      end
      if (i_cmd_valid && !ready)
        o_overrun <= 1'b1;
      o_rd_valid <= (state == EN_HI) && last && rw_q;
      if ((state == EN_HI) && last && rw_q)
        o_rd_data <= i_lcd_data;
    end
  end

  // Terminal states chain straight into SETUP so back-to-back commands lose no cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SETUP;
      SETUP:   if (last) state_next = EN_HI;
      EN_HI:   if (last) state_next = HOLD;
      HOLD:    if (last) state_next = rw_q ? (accept ? SETUP : IDLE) : EXEC;
      EXEC:    if (last) state_next = accept ? SETUP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_load = '0;
    case (state_next)
      SETUP:   cnt_load = CNT_W'(SETUP_CYC - 1);
      EN_HI:   cnt_load = CNT_W'(EN_HIGH_CYC - 1);
      HOLD:    cnt_load = CNT_W'(HOLD_CYC - 1);
      EXEC:    cnt_load = is_clear ? CNT_W'(CLEAR_EXEC_CYC - 1) : CNT_W'(EXEC_CYC - 1);
      default: cnt_load = '0;
    endcase
  end

  // Ready is also raised in the final busy cycle so the returning edge can accept.
  always_comb begin
    ready = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      HOLD:    ready = last && rw_q;
      EXEC:    ready = last;
      default: ready = 1'b0;
    endcase
    o_cmd_ready   = ready;
    o_busy        = !ready;
    o_lcd_on      = on_q;
    o_lcd_en      = (state == EN_HI);
    o_lcd_rs      = (state != IDLE) && rs_q;
    o_lcd_rw      = (state != IDLE) && rw_q;
    o_lcd_data    = (state != IDLE) ? data_q : 8'd0;
    o_lcd_data_oe = ((state == SETUP) || (state == EN_HI) || (state == HOLD)) && !rw_q;
  end

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Directed bench for lcd_bus_sequencer with short timing parameters.
module tb_lcd_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_data = 32'd0;
  logic        cmd_ready, busy, overrun, rd_valid;
  logic [7:0]  rd_data;
  logic        lcd_on, lcd_rs, lcd_rw, lcd_en, lcd_oe;
  logic [7:0]  lcd_data, lcd_in;

  int checks = 0;
  int errors = 0;
  int bus_viol = 0;

  int ready_n, en_first, en_count, pin_bad, rdv_count, on_seen;

  always #5 clk = ~clk;

  // The LCD model drives 0xA5 only while EN is high.
  assign lcd_in = lcd_en ? 8'hA5 : 8'h00;

  lcd_bus_sequencer #(
    .SETUP_CYC(2), .EN_HIGH_CYC(4), .HOLD_CYC(2), .EXEC_CYC(10),
    .CLEAR_EXEC_CYC(40), .CNT_W(17)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_cmd_valid(cmd_valid), .i_cmd_data(cmd_data),
    .o_cmd_ready(cmd_ready), .o_busy(busy), .o_overrun(overrun),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_lcd_on(lcd_on),
    .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw), .o_lcd_en(lcd_en),
    .o_lcd_data(lcd_data), .o_lcd_data_oe(lcd_oe), .i_lcd_data(lcd_in)
  );

  always @(negedge clk) if (lcd_oe && lcd_rw) bus_viol++;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge: issues one command and watches it to completion.
  task automatic apply_stimulus(input logic [31:0] cmd, input int extra_idx);
    ready_n = -1; en_first = -1; en_count = 0; pin_bad = 0; rdv_count = 0; on_seen = 0;
    cmd_data  = cmd;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) on_seen = int'(lcd_on);
      if (lcd_en) begin
        en_count++;
        if (en_first < 0) en_first = n;
      end
      if (rd_valid) rdv_count++;
      if (n <= 8 && (lcd_rs !== cmd[9] || lcd_rw !== cmd[8] || lcd_oe !== !cmd[8] ||
                     (!cmd[8] && lcd_data !== cmd[7:0])))
        pin_bad++;
      if (n == extra_idx) begin
        cmd_data  = 32'h8000_0255;
        cmd_valid = 1'b1;
      end else if (n == extra_idx + 1) begin
        cmd_valid = 1'b0;
      end
      if (cmd_ready) begin
        ready_n = n;
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    int hits, first_hit, second_hit;

    #12;
    check_output("reset_ready", cmd_ready, 1);
    check_output("reset_busy", busy, 0);
    check_output("reset_en", lcd_en, 0);
    check_output("reset_on", lcd_on, 0);
    check_output("reset_oe", lcd_oe, 0);
    check_output("reset_overrun", overrun, 0);
    check_output("reset_rd_data", rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    apply_stimulus(32'h8000_0238, 0);
    check_output("w38_on", on_seen, 1);
    check_output("w38_en_first", en_first, 3);
    check_output("w38_en_count", en_count, 4);
    check_output("w38_pins", pin_bad, 0);
    check_output("w38_ready", ready_n, 18);
    check_output("w38_overrun", overrun, 0);
    @(negedge clk);

    apply_stimulus(32'h8000_0001, 0);
    check_output("clear_ready", ready_n, 48);
    check_output("clear_pins", pin_bad, 0);
    @(negedge clk);
    apply_stimulus(32'h8000_0003, 0);
    check_output("home_ready", ready_n, 48);
    @(negedge clk);
    apply_stimulus(32'h8000_0004, 0);
    check_output("w04_ready", ready_n, 18);
    @(negedge clk);

    apply_stimulus(32'h8000_0100, 0);
    check_output("rd_ready", ready_n, 8);
    check_output("rd_pins", pin_bad, 0);
    check_output("rd_en_count", en_count, 4);
    check_output("rd_data", rd_data, 8'hA5);
    check_output("rd_valid_count", rdv_count, 1);
    @(negedge clk);

    apply_stimulus(32'h8000_0241, 3);
    check_output("ovr_pins", pin_bad, 0);
    check_output("ovr_ready", ready_n, 18);
    check_output("ovr_set", overrun, 1);
    @(negedge clk);
    check_output("ovr_idle_after", cmd_ready, 1);
    apply_stimulus(32'h8000_0004, 0);
    check_output("ovr_sticky", overrun, 1);
    @(negedge clk);

    cmd_data  = 32'h8000_0238;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_output("mid_en_high", lcd_en, 1);
    #1 rst_n = 1'b0;
    #1;
    check_output("async_en", lcd_en, 0);
    check_output("async_ready", cmd_ready, 1);
    check_output("async_on", lcd_on, 0);
    check_output("async_overrun", overrun, 0);
    check_output("async_pins", {lcd_rs, lcd_rw, lcd_oe, lcd_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(32'h8000_0238, 0);
    check_output("post_rst_en_first", en_first, 3);
    check_output("post_rst_ready", ready_n, 18);
    @(negedge clk);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    hits = 0; first_hit = -1; second_hit = -1;
    cmd_data  = 32'h8000_0230;
    cmd_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 54; n++) begin
      @(negedge clk);
      if (n == 1) check_output("hold_ovr_first", overrun, 0);
      if (n == 2) check_output("hold_ovr_busy", overrun, 1);
      if (cmd_ready) begin
        hits++;
        if (first_hit < 0) first_hit = n;
        else if (second_hit < 0) second_hit = n;
      end
    end
    cmd_valid = 1'b0;
    check_output("hold_accept_count", hits, 3);
    check_output("hold_first_period", first_hit, 18);
    check_output("hold_second_period", second_hit, 36);

    check_output("bus_rule", bus_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
